ofifo_reader: RTL and testbench
===============================

# ofifo_reader

Drain controller on the read side of the output FIFO. It pops completed psum rows (col lanes × bw bits) from the ofifo whenever the FIFO reports a full row valid. It optionally applies per-lane ReLU and writes each row into the psum SRAM at consecutive addresses from a programmed base. It sits between the ofifo and the psum memory, is started by the core controller once per tile, and reports completion with a one-cycle `done` pulse.

## Interface
- `col`, default 8: number of lanes per row; must match the ofifo.
- `bw`, default 16: bits per lane; lanes are signed two's complement.
- `addr_w`, default 11: psum SRAM address width.
- `rd_lat`, default 2: cycles from `fifo_rd` high to the popped row being stable on `fifo_out`; legal range 1–4.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to drain `num_rows` rows; sampled only in IDLE.
- `num_rows` in addr_w+1: number of rows to drain; sampled with `start`.
- `base_addr` in addr_w: SRAM address of the first row; sampled with `start`.
- `relu_en` in 1: enables per-lane ReLU; sampled with `start`.
- `fifo_valid` in 1: ofifo `o_valid`; high when every column FIFO holds at least one entry.
- `fifo_rd` out 1: pop request to ofifo `rd`.
- `fifo_out` in col*bw: ofifo `out`.
- `mem_wr` out 1: SRAM write strobe, active-high.
- `mem_addr` out addr_w: SRAM write address.
- `mem_din` out col*bw: SRAM write data.
- `busy` out 1: high while a drain is in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE → DRAIN on `start`.
  - DRAIN → FLUSH when issued count = `num_rows`.
  - FLUSH → DONE when no read is in flight and the last write has been issued.
  - DONE → IDLE unconditionally after one cycle.
- `start` with `num_rows`=0 goes IDLE → DONE directly. `start` outside IDLE is ignored.
- Single outstanding read:
  - `fifo_rd`=1 for exactly one cycle when the state is DRAIN, `fifo_valid`=1, the in-flight tracker is empty, and the issued count < `num_rows`.
  - This prevents over-popping while the ofifo's `o_valid` lags its read pointer.
- In-flight tracker: an `rd_lat`-deep shift register of valid bits. When a tag exits, `fifo_out` is captured.
- Capture path:
  - Each lane is transformed independently: if `relu_en` is set and the lane MSB is 1, the lane becomes 0; otherwise it passes unchanged.
  - The transformed row is registered into `mem_din`. `mem_addr` is set to `base_addr` + write index, mod 2^addr_w (wraps silently). `mem_wr` is pulsed.
- Write index and issued count are addr_w+1 bits and clear on `start`.
- `fifo_valid` dropping mid-drain stalls issue without error. There is no timeout.

## Timing
- Reset values (asynchronous on `reset_n`=0, held while low): state IDLE; `fifo_rd`, `mem_wr`, `busy`, `done` = 0; `mem_addr` = 0; `mem_din` = 0; tracker, counters and latched config cleared.
- Reset mid-drain aborts the drain immediately. No write is issued after the reset edge, and rows left in the ofifo are not touched.
- `start` high in cycle T → `busy`=1 from T+1. The earliest `fifo_rd` is in T+1.
- `fifo_rd` high in cycle R → `fifo_out` sampled at the end of cycle R+`rd_lat` → `mem_wr`/`mem_addr`/`mem_din` valid for one cycle in R+`rd_lat`+1.
- Steady-state throughput: one row per `rd_lat`+1 cycles.
- The last `mem_wr` is in cycle W → `done`=1 in W+1 and `busy`=0 from W+1.
- For `num_rows`=0: `done` in T+1 and `busy` stays 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `core_pkg`: `col`, `bw`, `addr_w` defaults, the ofifo read-latency constant, and the FSM state encoding (IDLE/DRAIN/FLUSH/DONE, 2 bits).
- One sub-module: `rd_lat_pipe`, a parameterised valid-bit shift register with `push`, `pop_valid` and `empty` outputs. It is reused by the ififo feeder.
- The ReLU is an inline generate loop over lanes; it is not a separate module.

## Test plan
- Reset then idle: `reset_n` low then high, no `start` → all outputs 0 for 20 cycles.
- Basic drain:
  - Stimulus: `start`, `num_rows`=4, `base_addr`=0x010, `relu_en`=0, `fifo_valid` stuck high, rows 0x0001…0x0004 broadcast on all lanes.
  - Response: writes to 0x010–0x013 with matching data, spaced 3 cycles apart, `done` one cycle after the 4th write.
- ReLU: lane values {-5, 7, 0x8000, 0x7FFF, 0, -1, 3, -32768} with `relu_en`=1 → `mem_din` lanes {0, 7, 0, 0x7FFF, 0, 0, 3, 0}.
- Stall and wrap:
  - Stimulus: `base_addr`=0x7FE, `num_rows`=4, `fifo_valid` low for 10 cycles after the 2nd pop.
  - Response: addresses 0x7FE, 0x7FF, 0x000, 0x001. No `fifo_rd` while `fifo_valid` is low, and never two `fifo_rd` within `rd_lat`+1 cycles.
- Edge cases:
  - `num_rows`=0 → `done` in T+1, no `fifo_rd`.
  - `start` pulsed again mid-drain → ignored, and the row count is unchanged.
- Reset mid-drain: `reset_n` low one cycle after the 2nd `fifo_rd` → no further `mem_wr`. A new `start` afterwards drains correctly from its own `base_addr`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants and FSM encoding for the core datapath controllers.
package core_pkg;

  localparam int DEF_COL      = 8;
  localparam int DEF_BW       = 16;
  localparam int DEF_ADDR_W   = 11;
  localparam int OFIFO_RD_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid-bit shift register that tracks reads in flight through a fixed-latency FIFO.
module rd_lat_pipe #(
  parameter int depth = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  output logic pop_valid,
  output logic empty
);

  logic [depth-1:0] tags;

  // empty means no tag remains after this edge; a tag exiting this cycle does not count
  generate
    if (depth == 1) begin : g_one
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tags <= '0;
        else          tags <= push;
      end
      assign empty = 1'b1;
    end else begin : g_many
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tags <= '0;
        else          tags <= {tags[depth-2:0], push};
      end
      assign empty = ~|tags[depth-2:0];
    end
  endgenerate

  assign pop_valid = tags[depth-1];

endmodule

// File: rtl/ofifo_reader.sv
// Drains psum rows from the ofifo, applies optional per-lane ReLU, and writes them to psum SRAM.
module ofifo_reader
  import core_pkg::*;
#(
  parameter int col    = DEF_COL,
  parameter int bw     = DEF_BW,
  parameter int addr_w = DEF_ADDR_W,
  parameter int rd_lat = OFIFO_RD_LAT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [addr_w:0]     num_rows,
  input  logic [addr_w-1:0]   base_addr,
  input  logic                relu_en,
  input  logic                fifo_valid,
  output logic                fifo_rd,
  input  logic [col*bw-1:0]   fifo_out,
  output logic                mem_wr,
  output logic [addr_w-1:0]   mem_addr,
  output logic [col*bw-1:0]   mem_din,
  output logic                busy,
  output logic                done
);

  state_t              state_reg, state_next;
  logic [addr_w:0]     rows_reg;
  logic [addr_w-1:0]   base_reg;
  logic                relu_reg;
  logic [addr_w:0]     issued_reg;
  logic [addr_w:0]     wr_idx_reg;
  logic                fifo_rd_reg, mem_wr_reg, busy_reg, done_reg;
  logic [addr_w-1:0]   mem_addr_reg;
  logic [col*bw-1:0]   mem_din_reg;
  logic [col*bw-1:0]   relu_row;
  logic                issue;
  logic                pop_valid, pipe_empty;

  rd_lat_pipe #(.depth(rd_lat)) u_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_rd_reg),
    .pop_valid (pop_valid),
    .empty     (pipe_empty)
  );

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_relu
      logic [bw-1:0] lane;
      assign lane = fifo_out[gi*bw +: bw];
      assign relu_row[gi*bw +: bw] = (relu_reg && lane[bw-1]) ? '0 : lane;
    end
  endgenerate

  // fifo_rd is registered, so issue looks one edge ahead: a pending fifo_rd counts as in flight
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (num_rows == '0) ? ST_DONE : ST_DRAIN;
          issue      = (num_rows != '0) && fifo_valid;
        end
      end
      ST_DRAIN: begin
        if (issued_reg == rows_reg) state_next = ST_FLUSH;
        else issue = fifo_valid && !fifo_rd_reg && pipe_empty;
      end
      ST_FLUSH: begin
        if (!fifo_rd_reg && !pop_valid && pipe_empty && (wr_idx_reg == rows_reg))
          state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      rows_reg     <= '0;
      base_reg     <= '0;
      relu_reg     <= 1'b0;
      issued_reg   <= '0;
      wr_idx_reg   <= '0;
      fifo_rd_reg  <= 1'b0;
      mem_wr_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      fifo_rd_reg <= issue;
      done_reg    <= (state_next == ST_DONE);
      busy_reg    <= (state_next == ST_DRAIN) || (state_next == ST_FLUSH);
      mem_wr_reg  <= pop_valid;
      if (state_reg == ST_IDLE && start) begin
        rows_reg   <= num_rows;
        base_reg   <= base_addr;
        relu_reg   <= relu_en;
        issued_reg <= (addr_w+1)'(issue);
        wr_idx_reg <= '0;
      end else if (issue) begin
        issued_reg <= issued_reg + (addr_w+1)'(1);
      end
      if (pop_valid) begin
        mem_din_reg  <= relu_row;
        mem_addr_reg <= base_reg + wr_idx_reg[addr_w-1:0];
        wr_idx_reg   <= wr_idx_reg + (addr_w+1)'(1);
      end
    end
  end

  assign fifo_rd  = fifo_rd_reg;
  assign mem_wr   = mem_wr_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_din  = mem_din_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_ofifo_reader.sv
// Directed bench for ofifo_reader with a behavioural ofifo read-latency model.
module tb_ofifo_reader;

  localparam int COL    = 8;
  localparam int BW     = 16;
  localparam int AW     = 11;
  localparam int RD_LAT = 2;
  localparam int RW     = COL * BW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW:0]   num_rows;
  logic [AW-1:0] base_addr;
  logic          relu_en;
  logic          fifo_valid;
  logic          fifo_rd;
  logic [RW-1:0] fifo_out;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_din;
  logic          busy;
  logic          done;

  ofifo_reader #(.col(COL), .bw(BW), .addr_w(AW), .rd_lat(RD_LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .num_rows   (num_rows),
    .base_addr  (base_addr),
    .relu_en    (relu_en),
    .fifo_valid (fifo_valid),
    .fifo_rd    (fifo_rd),
    .fifo_out   (fifo_out),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ofifo model: a pop at edge R presents its row on fifo_out RD_LAT cycles later
  logic [RW-1:0] row_q[$];
  logic [RW-1:0] pipe[RD_LAT];
  always @(posedge clk) begin
    if (fifo_rd) pipe[0] <= (row_q.size() > 0) ? row_q.pop_front() : '0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fifo_out = pipe[RD_LAT-1];

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [RW-1:0] d;
  } wr_t;
  wr_t wr_log[$];
  int  rd_log[$];
  int  done_log[$];

  always @(negedge clk) begin
    if (mem_wr)  wr_log.push_back('{cyc, mem_addr, mem_din});
    if (fifo_rd) rd_log.push_back(cyc);
    if (done)    done_log.push_back(cyc);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] bcast(input logic [BW-1:0] v);
    logic [RW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    done_log.delete();
  endtask

  task automatic do_start(input int rows, input int base, input logic relu, output int t);
    t         = cyc;
    start     = 1'b1;
    num_rows  = (AW+1)'(rows);
    base_addr = AW'(base);
    relu_en   = relu;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_log.size() == 0 && k < 200) begin step(); k++; end
    check({tag, "_done_seen"}, 256'(done_log.size() > 0), 256'(1));
    step();
  endtask

  task automatic wait_rd(input int n);
    int k = 0;
    while (rd_log.size() < n && k < 200) begin step(); k++; end
    check("rd_wait", 256'(rd_log.size() >= n), 256'(1));
  endtask

  task automatic wait_wr(input int n);
    int k = 0;
    while (wr_log.size() < n && k < 200) begin step(); k++; end
    check("wr_wait", 256'(wr_log.size() >= n), 256'(1));
  endtask

  int            t0, r2;
  logic [RW-1:0] relu_in, relu_exp;
  logic [15:0]   lanes_in  [COL];
  logic [15:0]   lanes_exp [COL];

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    num_rows   = '0;
    base_addr  = '0;
    relu_en    = 1'b0;
    fifo_valid = 1'b0;

    // reset and idle
    step(); step();
    check("reset_outs", {fifo_rd, mem_wr, busy, done, mem_addr, mem_din}, '0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_outs", {fifo_rd, mem_wr, busy, done, mem_addr, mem_din}, '0);
    end

    // basic drain: 4 rows, base 0x010, spacing RD_LAT+1
    clear_logs();
    for (int i = 1; i <= 4; i++) row_q.push_back(bcast(16'(i)));
    fifo_valid = 1'b1;
    do_start(4, 'h010, 1'b0, t0);
    check("basic_busy_t1", {busy, fifo_rd}, 2'b11);
    wait_done("basic");
    check("basic_nwr", wr_log.size(), 4);
    check("basic_rd0_cyc", rd_log[0], t0 + 1);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      $display("basic write %0d: cyc %0d addr %03h data %0h", i, wr_log[i].c, wr_log[i].a, wr_log[i].d);
      check("basic_addr", wr_log[i].a, 'h010 + i);
      check("basic_data", wr_log[i].d, bcast(16'(i + 1)));
      check("basic_cyc", wr_log[i].c, t0 + 4 + 3 * i);
    end
    check("basic_done_cyc", done_log[0], t0 + 14);
    check("basic_idle_after", {busy, done}, 2'b00);

    // ReLU enabled, then the same row with ReLU disabled
    lanes_in  = '{16'hFFFB, 16'h0007, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0003, 16'h8000};
    lanes_exp = '{16'h0000, 16'h0007, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0003, 16'h0000};
    for (int i = 0; i < COL; i++) begin
      relu_in[i*BW +: BW]  = lanes_in[i];
      relu_exp[i*BW +: BW] = lanes_exp[i];
    end
    clear_logs();
    row_q.push_back(relu_in);
    do_start(1, 'h020, 1'b1, t0);
    wait_done("relu");
    $display("relu write: addr %03h data %0h", wr_log[0].a, wr_log[0].d);
    check("relu_on_data", wr_log[0].d, relu_exp);
    check("relu_on_addr", wr_log[0].a, 'h020);
    clear_logs();
    row_q.push_back(relu_in);
    do_start(1, 'h021, 1'b0, t0);
    wait_done("relu_off");
    $display("relu-off write: addr %03h data %0h", wr_log[0].a, wr_log[0].d);
    check("relu_off_data", wr_log[0].d, relu_in);

    // stall after the 2nd pop, address wrap from 0x7FE
    clear_logs();
    for (int i = 0; i < 4; i++) row_q.push_back(bcast(16'h0011 + 16'(i)));
    do_start(4, 'h7FE, 1'b0, t0);
    wait_rd(2);
    r2 = cyc;
    fifo_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_no_rd", fifo_rd, 1'b0);
    end
    fifo_valid = 1'b1;
    wait_done("stall");
    check("stall_nwr", wr_log.size(), 4);
    check("stall_rd2_cyc", rd_log[2], r2 + 11);
    for (int i = 1; i < rd_log.size(); i++)
      check("stall_rd_gap", 256'(rd_log[i] - rd_log[i-1] >= RD_LAT + 1), 256'(1));
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      $display("wrap write %0d: cyc %0d addr %03h data %0h", i, wr_log[i].c, wr_log[i].a, wr_log[i].d);
      check("wrap_addr", wr_log[i].a, (('h7FE + i) % 2048));
      check("wrap_data", wr_log[i].d, bcast(16'h0011 + 16'(i)));
    end

    // num_rows = 0
    clear_logs();
    do_start(0, 'h055, 1'b0, t0);
    check("zero_done_t1", {done, busy, fifo_rd}, 3'b100);
    step();
    check("zero_done_pulse", {done, busy}, 2'b00);
    check("zero_no_rd", rd_log.size(), 0);

    // start pulsed mid-drain is ignored
    clear_logs();
    for (int i = 0; i < 5; i++) row_q.push_back(bcast(16'h0A00 + 16'(i)));
    do_start(3, 'h100, 1'b0, t0);
    wait_wr(1);
    do_start(5, 'h200, 1'b0, t0);
    wait_done("midstart");
    check("midstart_nwr", wr_log.size(), 3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      $display("midstart write %0d: addr %03h data %0h", i, wr_log[i].a, wr_log[i].d);
      check("midstart_addr", wr_log[i].a, 'h100 + i);
    end
    check("midstart_left", row_q.size(), 2);
    row_q.delete();

    // reset one cycle after the 2nd pop aborts the drain
    clear_logs();
    for (int i = 0; i < 4; i++) row_q.push_back(bcast(16'h0021 + 16'(i)));
    do_start(4, 'h040, 1'b0, t0);
    wait_rd(2);
    step();
    reset_n = 1'b0;
    step();
    check("rst_mid_outs", {fifo_rd, mem_wr, busy, done, mem_addr, mem_din}, '0);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("rst_mid_nwr", wr_log.size(), 1);
    check("rst_mid_left", row_q.size(), 2);
    check("rst_mid_idle", {busy, done}, 2'b00);

    // fresh drain after the abort
    row_q.delete();
    clear_logs();
    row_q.push_back(bcast(16'h0031));
    row_q.push_back(bcast(16'h0032));
    do_start(2, 'h300, 1'b0, t0);
    wait_done("post_rst");
    check("post_rst_nwr", wr_log.size(), 2);
    for (int i = 0; i < 2 && i < wr_log.size(); i++) begin
      $display("post-reset write %0d: addr %03h data %0h", i, wr_log[i].a, wr_log[i].d);
      check("post_rst_addr", wr_log[i].a, 'h300 + i);
      check("post_rst_data", wr_log[i].d, bcast(16'h0031 + 16'(i)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
